// File: rtl/mem_arbiter_pkg.sv
// Shared types and width defaults for the round-robin memory burst arbiter.
// Width macros fall back to local defaults when the global header is absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 1
`endif

package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W = `ADDR_WIDTH;
    localparam int DEF_DATA_W = `DATA_WIDTH * `BANDWIDTH;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the memory arbiter.
// The master modport is the arbiter's view; slave is the requesters plus memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             grant;
    logic                           beat;
    logic [LEN_W-1:0]               beat_idx;
    logic [NUM_REQ-1:0]             done;
    logic                           rvalid;
    logic [ID_W-1:0]                rid;
    logic [DATA_W-1:0]              rdata;
    logic                           mem_read;
    logic                           mem_write;
    logic [ADDR_W-1:0]              mem_address;
    logic [DATA_W-1:0]              mem_writedata;
    logic [DATA_W-1:0]              mem_readdata;

    modport master (
        input  req, req_write, req_addr, req_len, req_wdata, mem_readdata,
        output grant, beat, beat_idx, done, rvalid, rid, rdata,
               mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        output req, req_write, req_addr, req_len, req_wdata, mem_readdata,
        input  grant, beat, beat_idx, done, rvalid, rid, rdata,
               mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Kept generic so other shared-resource arbiters can reuse it.
module rr_pick #(
    parameter  int N    = 3,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    win_o,
    output logic [ID_W-1:0] win_id_o
);

    int   idx;
    logic found;

    always_comb begin
        win_o    = '0;
        win_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                win_o[idx] = 1'b1;
                win_id_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port, 1-cycle-read word memory
// among NUM_REQ requesters; the arbiter generates burst addresses itself.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.master bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t         state_q;
    logic [ID_W-1:0]    rrPtr_q;
    logic [ID_W-1:0]    owner_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beatIdx_q;
    logic [ADDR_W-1:0]  memAddr_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               beat_q;
    logic               memRead_q;
    logic               memWrite_q;
    logic               rvalid_q;
    logic [ID_W-1:0]    rid_q;

    logic [NUM_REQ-1:0] pickWin_d;
    logic [ID_W-1:0]    pickId_d;
    logic [LEN_W-1:0]   nextIdx_d;
    logic [ID_W-1:0]    ptrNext_d;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (rrPtr_q),
        .win_o    (pickWin_d),
        .win_id_o (pickId_d)
    );

    assign nextIdx_d = beatIdx_q + LEN_W'(1);
    assign ptrNext_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // Outputs are registered one cycle ahead so each beat's strobes, address
    // and done pulse line up in the same cycle the memory sees them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            owner_q    <= '0;
            len_q      <= '0;
            beatIdx_q  <= '0;
            memAddr_q  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            beat_q     <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q    <= BURST;
                        owner_q    <= pickId_d;
                        len_q      <= bus.req_len[pickId_d];
                        beatIdx_q  <= '0;
                        memAddr_q  <= bus.req_addr[pickId_d];
                        grant_q    <= pickWin_d;
                        beat_q     <= 1'b1;
                        memRead_q  <= !bus.req_write[pickId_d];
                        memWrite_q <= bus.req_write[pickId_d];
                        done_q     <= (bus.req_len[pickId_d] == '0) ? pickWin_d : '0;
                    end
                end
                BURST: begin
                    if (beatIdx_q == len_q) begin
                        state_q    <= IDLE;
                        rrPtr_q    <= ptrNext_d;
                        beatIdx_q  <= '0;
                        memAddr_q  <= '0;
                        grant_q    <= '0;
                        done_q     <= '0;
                        beat_q     <= 1'b0;
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                    end else begin
                        beatIdx_q <= nextIdx_d;
                        memAddr_q <= memAddr_q + ADDR_W'(1);
                        done_q    <= (nextIdx_d == len_q) ? grant_q : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= memRead_q;
            rid_q    <= memRead_q ? owner_q : '0;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.beat          = beat_q;
    assign bus.beat_idx      = beatIdx_q;
    assign bus.done          = done_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.rid           = rid_q;
    assign bus.rdata         = bus.mem_readdata;
    assign bus.mem_read      = memRead_q;
    assign bus.mem_write     = memWrite_q;
    assign bus.mem_address   = memAddr_q;
    assign bus.mem_writedata = memWrite_q ? bus.req_wdata[owner_q] : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fakemem-style 1-cycle registered memory.
module tb_mem_arbiter;

    localparam int NR = 3;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] readData;

    always @(posedge clock) begin
        if (bus.mem_read) readData <= mem[bus.mem_address];
        if (bus.mem_write) mem[bus.mem_address] = bus.mem_writedata;
    end

    assign bus.mem_readdata = readData;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=000", bus.grant); end
        checks++; if (bus.beat !== 1'b0) begin failures++; $display("[TB] FAIL reset_beat got=%b exp=0", bus.beat); end
        checks++; if (bus.done !== 3'b000) begin failures++; $display("[TB] FAIL reset_done got=%b exp=000", bus.done); end
        checks++; if ({bus.rvalid, bus.rid} !== 3'b000) begin failures++; $display("[TB] FAIL reset_rvalid_rid got=%b exp=000", {bus.rvalid, bus.rid}); end
        checks++; if ({bus.mem_read, bus.mem_write, bus.mem_address} !== 8'h00) begin failures++; $display("[TB] FAIL reset_mem got=%h exp=00", {bus.mem_read, bus.mem_write, bus.mem_address}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        bus.req_addr[0]  = 6'd1;
        bus.req_len[0]   = 8'd0;
        bus.req_write[0] = 1'b0;
        bus.req          = 3'b001;
        tick();
        checks++; if (bus.grant !== 3'b001) begin failures++; $display("[TB] FAIL single_grant got=%b exp=001", bus.grant); end
        checks++; if ({bus.mem_read, bus.mem_write, bus.mem_address} !== {1'b1, 1'b0, 6'd1}) begin failures++; $display("[TB] FAIL single_mem got=%b%b/%0d exp=10/1", bus.mem_read, bus.mem_write, bus.mem_address); end
        checks++; if (bus.done !== 3'b001) begin failures++; $display("[TB] FAIL single_done got=%b exp=001", bus.done); end
        bus.req = 3'b000;
        tick();
        checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd0, 32'h40A00000}) begin failures++; $display("[TB] FAIL single_rdata got=%b/%0d/%h exp=1/0/40a00000", bus.rvalid, bus.rid, bus.rdata); end
        checks++; if ({bus.grant, bus.beat} !== 4'b0000) begin failures++; $display("[TB] FAIL single_idle got=%b exp=0000", {bus.grant, bus.beat}); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_rvalid_off got=%b exp=0", bus.rvalid); end
    endtask

    task automatic test_read_burst();
        logic [DW-1:0] expData [4];
        expData = '{32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
        bus.req_addr[1]  = 6'd30;
        bus.req_len[1]   = 8'd3;
        bus.req_write[1] = 1'b0;
        bus.req          = 3'b010;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 4) begin
                checks++; if ({bus.grant, bus.mem_read, bus.mem_address} !== {3'b010, 1'b1, 6'(30 + c)}) begin failures++; $display("[TB] FAIL burst_addr beat=%0d got=%b/%b/%0d exp=010/1/%0d", c, bus.grant, bus.mem_read, bus.mem_address, 30 + c); end
                checks++; if (bus.done !== ((c == 3) ? 3'b010 : 3'b000)) begin failures++; $display("[TB] FAIL burst_done beat=%0d got=%b", c, bus.done); end
                if (bus.done[1]) bus.req = 3'b000;
            end
            if (c > 0) begin
                checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd1, expData[c-1]}) begin failures++; $display("[TB] FAIL burst_rdata beat=%0d got=%b/%0d/%h exp=1/1/%h", c - 1, bus.rvalid, bus.rid, bus.rdata, expData[c-1]); end
            end
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] seen [$];
        logic [NR-1:0] expGrant [4];
        bit            rearmed = 1'b0;
        expGrant = '{3'b001, 3'b010, 3'b100, 3'b001};
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int r = 0; r < NR; r++) begin
            bus.req_addr[r]  = 6'(r * 10);
            bus.req_len[r]   = 8'd1;
            bus.req_write[r] = 1'b0;
        end
        bus.req = 3'b111;
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            tick();
            if (bus.beat && bus.beat_idx == 8'd0) seen.push_back(bus.grant);
            if (bus.beat && bus.grant == 3'b010 && !rearmed) begin
                bus.req[0] = 1'b1;
                rearmed    = 1'b1;
            end
            bus.req = bus.req & ~bus.done;
        end
        checks++; if (seen.size() != 4) begin failures++; $display("[TB] FAIL contention_count got=%0d exp=4", seen.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) begin
                checks++; if (seen[i] !== expGrant[i]) begin failures++; $display("[TB] FAIL contention_order idx=%0d got=%b exp=%b", i, seen[i], expGrant[i]); end
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.req = bus.req & ~bus.done;
        end
        bus.req = 3'b000;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] expAddr [4];
        logic [DW-1:0] expData [4];
        expAddr = '{6'd62, 6'd63, 6'd0, 6'd1};
        expData = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h40A00000};
        bus.req_addr[0]  = 6'd62;
        bus.req_len[0]   = 8'd3;
        bus.req_write[0] = 1'b0;
        bus.req          = 3'b001;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 4) begin
                checks++; if ({bus.grant, bus.mem_address} !== {3'b001, expAddr[c]}) begin failures++; $display("[TB] FAIL wrap_addr beat=%0d got=%b/%0d exp=001/%0d", c, bus.grant, bus.mem_address, expAddr[c]); end
                if (bus.done[0]) bus.req = 3'b000;
            end
            if (c > 0) begin
                checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd0, expData[c-1]}) begin failures++; $display("[TB] FAIL wrap_rdata beat=%0d got=%b/%0d/%h exp=1/0/%h", c - 1, bus.rvalid, bus.rid, bus.rdata, expData[c-1]); end
            end
        end
        bus.req = 3'b000;
    endtask

    task automatic test_write_burst();
        bus.req_addr[2]  = 6'd5;
        bus.req_len[2]   = 8'd1;
        bus.req_write[2] = 1'b1;
        bus.req_wdata[2] = 32'hA;
        bus.req          = 3'b100;
        for (int c = 0; c < 2; c++) begin
            tick();
            bus.req_wdata[2] = (bus.beat_idx == 8'd0) ? 32'hA : 32'hB;
            #1;
            checks++; if ({bus.grant, bus.mem_write, bus.mem_read, bus.mem_address} !== {3'b100, 1'b1, 1'b0, 6'(5 + c)}) begin failures++; $display("[TB] FAIL write_strobe beat=%0d got=%b/%b%b/%0d exp=100/10/%0d", c, bus.grant, bus.mem_write, bus.mem_read, bus.mem_address, 5 + c); end
            checks++; if (bus.mem_writedata !== ((c == 0) ? 32'hA : 32'hB)) begin failures++; $display("[TB] FAIL write_data beat=%0d got=%h", c, bus.mem_writedata); end
            if (bus.done[2]) bus.req = 3'b000;
        end
        tick();
        checks++; if ({bus.beat, bus.mem_write, bus.rvalid} !== 3'b000) begin failures++; $display("[TB] FAIL write_after got=%b exp=000", {bus.beat, bus.mem_write, bus.rvalid}); end
        checks++; if ({mem[5], mem[6]} !== {32'hA, 32'hB}) begin failures++; $display("[TB] FAIL write_mem got=%h/%h exp=a/b", mem[5], mem[6]); end
        bus.req = 3'b000;
        bus.req_write[2] = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bus.req_addr[0]  = 6'd30;
        bus.req_len[0]   = 8'd3;
        bus.req_write[0] = 1'b0;
        bus.req          = 3'b001;
        tick();
        tick();
        checks++; if ({bus.grant, bus.beat_idx} !== {3'b001, 8'd1}) begin failures++; $display("[TB] FAIL rstmid_pre got=%b/%0d exp=001/1", bus.grant, bus.beat_idx); end
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.grant, bus.beat, bus.done, bus.rvalid, bus.mem_read, bus.mem_write, bus.mem_address} !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_async got=%h exp=0000", {bus.grant, bus.beat, bus.done, bus.rvalid, bus.mem_read, bus.mem_write, bus.mem_address}); end
        bus.req = 3'b000;
        tick();
        checks++; if ({bus.done, bus.rvalid} !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_held got=%b exp=0000", {bus.done, bus.rvalid}); end
        bus.req_addr[1]  = 6'd1;
        bus.req_len[1]   = 8'd0;
        bus.req_write[1] = 1'b0;
        bus.req          = 3'b010;
        reset_n          = 1'b1;
        tick();
        checks++; if ({bus.grant, bus.done} !== {3'b010, 3'b010}) begin failures++; $display("[TB] FAIL rstmid_regrant got=%b/%b exp=010/010", bus.grant, bus.done); end
        bus.req = 3'b000;
        tick();
        checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd1, 32'h40A00000}) begin failures++; $display("[TB] FAIL rstmid_rdata got=%b/%0d/%h exp=1/1/40a00000", bus.rvalid, bus.rid, bus.rdata); end
    endtask

    task automatic test_max_len();
        int         beats   = 0;
        bit         gotDone = 1'b0;
        logic [7:0] doneIdx = '0;
        bus.req_addr[0]  = 6'd0;
        bus.req_len[0]   = 8'd255;
        bus.req_write[0] = 1'b0;
        bus.req          = 3'b001;
        for (int c = 0; c < 300 && !gotDone; c++) begin
            tick();
            if (bus.beat) beats++;
            if (bus.done[0]) begin
                gotDone = 1'b1;
                doneIdx = bus.beat_idx;
                bus.req = 3'b000;
            end
        end
        checks++; if (gotDone !== 1'b1) begin failures++; $display("[TB] FAIL maxlen_done got=%b exp=1", gotDone); end
        checks++; if (beats != 256) begin failures++; $display("[TB] FAIL maxlen_beats got=%0d exp=256", beats); end
        checks++; if (doneIdx !== 8'd255) begin failures++; $display("[TB] FAIL maxlen_idx got=%0d exp=255", doneIdx); end
        tick();
        checks++; if ({bus.beat, bus.grant} !== 4'b0000) begin failures++; $display("[TB] FAIL maxlen_end got=%b exp=0000", {bus.beat, bus.grant}); end
        bus.req = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1]  = 32'h40A00000;
        mem[30] = 32'h41200000;
        mem[31] = 32'h41400000;
        mem[32] = 32'h41600000;
        mem[33] = 32'h41800000;
        mem[62] = 32'h11111111;
        mem[63] = 32'h22222222;
        mem[0]  = 32'h33333333;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;

        test_reset();
        test_single_read();
        test_read_burst();
        test_contention();
        test_wrap();
        test_write_burst();
        test_reset_mid_burst();
        test_max_len();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin burst arbiter that shares one single-port word memory (the `M10KControl`/`fakemem`-style port: `read`, `write`, `address`, `writedata`, `readdata`, 1-cycle registered read) among `NUM_REQ` datapath requesters such as the tensor loader, matrix unit and writeback. A granted requester owns the port for a whole burst of consecutive addresses, and the arbiter generates the addresses. Read data returns tagged with the owner's ID. The block sits between the compute units and the memory wrapper.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `ADDR_W`, `` `ADDR_WIDTH ``, memory address width
- `DATA_W`, `` `DATA_WIDTH*`BANDWIDTH ``, memory word width
- `LEN_W`, 8, burst length field width

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request; held until its `done`
- `req_write`  in  NUM_REQ  1 = write burst, 0 = read burst
- `req_addr`  in  NUM_REQ x ADDR_W  burst base address
- `req_len`  in  NUM_REQ x LEN_W  beats minus one (0 = 1 beat)
- `req_wdata`  in  NUM_REQ x DATA_W  write word for the current beat
- `grant`  out  NUM_REQ  one-hot owner, held for the whole burst
- `beat`  out  1  a memory op is issued this cycle
- `beat_idx`  out  LEN_W  index of the current beat
- `done`  out  NUM_REQ  one-cycle pulse on the owner's bit at the last beat
- `rvalid`  out  1  `rdata` valid
- `rid`  out  $clog2(NUM_REQ)  owner of `rdata`
- `rdata`  out  DATA_W  read word
- `mem_read`, `mem_write`  out  1  memory strobes
- `mem_address`  out  ADDR_W  memory address
- `mem_writedata`  out  DATA_W  memory write word
- `mem_readdata`  in  DATA_W  memory read word, valid 1 cycle after `mem_read`

## Operation
- FSM states: `IDLE`, `BURST`.
- **IDLE:**
  - If any `req` is high, the picker selects the first set bit at or after `rr_ptr`, wrapping around.
  - The block latches the winner ID, `req_write`, `req_addr` and `req_len`, then goes to `BURST`.
  - If no `req` is high, it stays in `IDLE`.
- **BURST:**
  - Each cycle: `beat`=1, `mem_address` = base + `beat_idx` (mod 2^ADDR_W, so the address wraps).
  - Exactly one of `mem_read`/`mem_write` is high.
  - `mem_writedata` = `req_wdata[owner]`, passed through combinationally. The requester drives the word for `beat_idx` during that cycle.
  - When `beat_idx` == len: pulse `done[owner]`, set `rr_ptr` = owner+1 (mod NUM_REQ), go to `IDLE`.
  - Otherwise increment `beat_idx`.
- Dropping `req` mid-burst has no effect; the burst completes.
- Raising `req` while another requester owns the port waits for `IDLE`.
- Read return:
  - `rvalid` and `rid` are `mem_read` and owner delayed by one register.
  - `rdata` = `mem_readdata`, passed through.
  - A read return can overlap the next `IDLE` cycle or the next burst.
- Outputs are 0 whenever `beat`=0: `mem_*`, `grant`, `beat_idx`.

## Timing
- Reset (asynchronous, effective immediately): state=`IDLE`, `rr_ptr`=0, counter=0. All outputs are 0: `grant`, `beat`, `done`, `rvalid`, `rid`, `mem_read`, `mem_write`, `mem_address`. `rdata` follows `mem_readdata`, but it is don't-care while `rvalid`=0.
- Request to first beat: `req` seen in `IDLE` at cycle t gives `grant` and the first beat at t+1.
- Read data: `rvalid` for beat k arrives at t+2+k.
- A burst of L+1 beats occupies cycles t+1..t+1+L. `IDLE` is at t+2+L, so there is a 1-cycle gap between bursts.
- Back-to-back throughput for a single requester: (L+1)/(L+2).
- Fairness: with all requesters requesting continuously, grants rotate 0,1,2,0,… After a grant to i, every other active requester is served before i again.
- Reset asserted mid-burst: the burst is abandoned, no `done` is issued, and an in-flight `rvalid` is suppressed.
- `req_len` at its maximum (2^LEN_W−1) yields 2^LEN_W beats; `beat_idx` must not overflow.

## Structure
- Package `mem_arb_pkg`: state enum `arb_state_t` {`IDLE`, `BURST`}, and the `ADDR_W`/`DATA_W` defaults derived from the global width macros.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs one-hot `win` and binary `win_id`. It is reused by other shared-resource arbiters.
- Top level holds: FSM, burst counter, latched burst descriptor, `rr_ptr`, and the one-stage read-return register.

## Test plan
Bench: NUM_REQ=3, ADDR_W=6, memory = `fakemem` (mem[1] = 0x40A00000, mem[30..33] = float 10, 12, 14, 16).
- Single read: req0 with addr=1, len=0 → `grant`=001 one cycle later; `rvalid`, `rid`=0, `rdata`=0x40A00000 two cycles after `req`; `done[0]` pulses with the beat.
- Read burst: req1 with addr=30, len=3 → `mem_address` 30, 31, 32, 33 on consecutive cycles; `rdata` = 0x41200000, 0x41400000, 0x41600000, 0x41800000, all with `rid`=1.
- Contention: all three requesters raise `req` together with len=1 → `grant` order 0, 1, 2. Then req0 re-requests while req2 is pending → req2 is served before req0.
- Wrap-around: read with addr=62, len=3 → addresses 62, 63, 0, 1.
- Write burst: req2 with addr=5, len=1, `req_wdata` = 0xA, then 0xB keyed by `beat_idx` → `mem_write` high 2 cycles; `mem_writedata` = 0xA, then 0xB; `mem_read` stays 0.
- Reset mid-burst: `reset_n` low at the 2nd beat of a len=3 burst → all outputs 0 immediately, no `done`, no `rvalid`. After release, a new req1 is granted, since `rr_ptr`=0 and only req1 is active.
